// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the emulated SPI ADC responder.
package adc_emu_pkg;

  localparam int DATA_BITS_DEFAULT   = 10;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_GET_SGL,
    ST_GET_ODD,
    ST_GET_MSBF,
    ST_NULL_BIT,
    ST_DATA,
    ST_LSB_TAIL,
    ST_ZERO_FILL
  } state_e;

  // States in which a CS rise means the conversion result never fully left.
  function automatic logic frame_abortable(input state_e s);
    return s inside {ST_GET_SGL, ST_GET_ODD, ST_GET_MSBF, ST_NULL_BIT, ST_DATA};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser chain plus registered rise/fall pulses for one asynchronous input.
module spi_edge_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{IDLE_VAL}};
      prev_q <= IDLE_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/adc_spi_responder.sv
// Device side of a 3-wire-config SPI ADC: decodes the start/SGL/ODD/MSBF header
// and streams back a latched single-ended or saturated differential result.
module adc_spi_responder
  import adc_emu_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int DATA_BITS   = DATA_BITS_DEFAULT
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 adc_cs,
  input  logic                 adc_sck,
  input  logic                 sdata_to_adc,
  input  logic [DATA_BITS-1:0] sample_ch0,
  input  logic [DATA_BITS-1:0] sample_ch1,
  output logic                 sdata_from_adc,
  output logic                 sdo_oe,
  output logic                 conv_done,
  output logic                 frame_error,
  output logic                 last_channel,
  output state_e               dbg_state_o
);

  localparam int CW = $clog2(DATA_BITS);

  logic                   sck_rise;
  logic                   sck_fall;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic [SYNC_STAGES-1:0] init_q;
  logic                   armed_q;
  logic                   cs;
  logic                   sdi;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_BITS-1:0]   res_q;
  logic [DATA_BITS-1:0]   res_d;
  logic                   sgl_q;
  logic                   odd_q;
  logic                   msbf_q;
  logic                   sdo_q;
  logic                   oe_q;
  logic                   conv_done_q;
  logic                   frame_error_q;
  logic                   last_channel_q;

  spi_edge_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (1'b1)
  ) u_sck_sync (
    .clk_i  (sysclk),
    .rst_ni (rst_n),
    .d_i    (adc_sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  // init_q marks when the CS chain holds real samples instead of reset values, so
  // a reset released mid-frame cannot mistake the chain draining for a CS fall.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= {SYNC_STAGES{1'b1}};
      sdi_sync_q <= '0;
      init_q     <= '0;
      armed_q    <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdata_to_adc};
      init_q     <= {init_q[SYNC_STAGES-2:0], 1'b1};
      armed_q    <= armed_q | (init_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES-1]);
    end
  end

  assign cs  = cs_sync_q[SYNC_STAGES-1];
  assign sdi = sdi_sync_q[SYNC_STAGES-1];

  always_comb begin
    res_d = '0;
    if (sgl_q) begin
      res_d = odd_q ? sample_ch1 : sample_ch0;
    end else if (!odd_q) begin
      res_d = (sample_ch0 > sample_ch1) ? sample_ch0 - sample_ch1 : '0;
    end else begin
      res_d = (sample_ch1 > sample_ch0) ? sample_ch1 - sample_ch0 : '0;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      res_q          <= '0;
      sgl_q          <= 1'b0;
      odd_q          <= 1'b0;
      msbf_q         <= 1'b0;
      sdo_q          <= 1'b0;
      oe_q           <= 1'b0;
      conv_done_q    <= 1'b0;
      frame_error_q  <= 1'b0;
      last_channel_q <= 1'b0;
    end else begin
      conv_done_q   <= 1'b0;
      frame_error_q <= 1'b0;
      if (state_q != ST_IDLE && cs) begin
        state_q       <= ST_IDLE;
        sdo_q         <= 1'b0;
        oe_q          <= 1'b0;
        frame_error_q <= frame_abortable(state_q);
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (armed_q && !cs) state_q <= ST_WAIT_START;
          end
          ST_WAIT_START: begin
            if (sck_rise && sdi) state_q <= ST_GET_SGL;
          end
          ST_GET_SGL: begin
            if (sck_rise) begin
              sgl_q   <= sdi;
              state_q <= ST_GET_ODD;
            end
          end
          ST_GET_ODD: begin
            if (sck_rise) begin
              odd_q   <= sdi;
              state_q <= ST_GET_MSBF;
            end
          end
          ST_GET_MSBF: begin
            if (sck_rise) begin
              msbf_q         <= sdi;
              res_q          <= res_d;
              last_channel_q <= odd_q;
              state_q        <= ST_NULL_BIT;
            end
          end
          ST_NULL_BIT: begin
            if (sck_fall) begin
              sdo_q   <= 1'b0;
              oe_q    <= 1'b1;
              cnt_q   <= CW'(DATA_BITS - 1);
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sck_fall) begin
              sdo_q <= res_q[cnt_q];
              if (cnt_q == '0) begin
                conv_done_q <= 1'b1;
                cnt_q       <= CW'(1);
                state_q     <= msbf_q ? ST_ZERO_FILL : ST_LSB_TAIL;
              end else begin
                cnt_q <= cnt_q - CW'(1);
              end
            end
          end
          ST_LSB_TAIL: begin
            if (sck_fall) begin
              sdo_q <= res_q[cnt_q];
              if (cnt_q == CW'(DATA_BITS - 1)) state_q <= ST_ZERO_FILL;
              else cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_ZERO_FILL: begin
            if (sck_fall) sdo_q <= 1'b0;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign sdata_from_adc = sdo_q;
  assign sdo_oe         = oe_q;
  assign conv_done      = conv_done_q;
  assign frame_error    = frame_error_q;
  assign last_channel   = last_channel_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed frames against a bit-stream model of the ADC responder, checked every cycle.
module tb_adc_spi_responder;
  import adc_emu_pkg::*;

  localparam int S  = 2;
  localparam int DB = 10;

  logic          sysclk = 1'b0;
  logic          rst_n;
  logic          adc_cs;
  logic          adc_sck;
  logic          sdata_to_adc;
  logic [DB-1:0] sample_ch0;
  logic [DB-1:0] sample_ch1;
  logic          sdata_from_adc;
  logic          sdo_oe;
  logic          conv_done;
  logic          frame_error;
  logic          last_channel;
  state_e        dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int conv_cnt = 0;
  int ferr_cnt = 0;

  // Expected {care, data_tag, oe, sdo}, each taking effect at a given cycle.
  int          due_cyc[$];
  logic [3:0]  due_ent[$];
  logic [3:0]  cur = 4'b1000;
  logic [31:0] obs_bits = '0;
  logic        conv_prev = 1'b0;
  logic        ferr_prev = 1'b0;
  logic        model_lc = 1'b0;

  adc_spi_responder #(
    .SYNC_STAGES (S),
    .DATA_BITS   (DB)
  ) dut (
    .sysclk         (sysclk),
    .rst_n          (rst_n),
    .adc_cs         (adc_cs),
    .adc_sck        (adc_sck),
    .sdata_to_adc   (sdata_to_adc),
    .sample_ch0     (sample_ch0),
    .sample_ch1     (sample_ch1),
    .sdata_from_adc (sdata_from_adc),
    .sdo_oe         (sdo_oe),
    .conv_done      (conv_done),
    .frame_error    (frame_error),
    .last_channel   (last_channel),
    .dbg_state_o    (dbg_state)
  );

  always #10 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic sched(input int due, input logic [3:0] ent);
    due_cyc.push_back(due);
    due_ent.push_back(ent);
  endtask

  function automatic int model_result(input bit sgl, input bit odd, input int c0, input int c1);
    int d;
    if (sgl) return odd ? c1 : c0;
    d = odd ? c1 - c0 : c0 - c1;
    return (d < 0) ? 0 : d;
  endfunction

  function automatic bit master_bit(input int f, input int lead, input bit sgl,
                                    input bit odd, input bit msbf);
    if (f < lead)      return 1'b0;
    if (f == lead)     return 1'b1;
    if (f == lead + 1) return sgl;
    if (f == lead + 2) return odd;
    if (f == lead + 3) return msbf;
    return 1'b0;
  endfunction

  // {data_tag, oe, sdo} after falling edge f of the frame.
  function automatic logic [2:0] model_fall(input int f, input int lead, input int res, input bit msbf);
    int k;
    k = f - lead - 4;
    if (k < 0)   return 3'b000;
    if (k == 0)  return 3'b010;
    if (k <= DB) return {2'b11, 1'((res >> (DB - k)) & 1)};
    if (!msbf && k <= 2 * DB - 1) return {2'b11, 1'((res >> (k - DB)) & 1)};
    return 3'b010;
  endfunction

  always @(negedge sysclk) begin
    int tmp;
    while (due_cyc.size() > 0 && due_cyc[0] <= cyc) begin
      tmp = due_cyc.pop_front();
      cur = due_ent.pop_front();
      if (cur[2]) obs_bits = {obs_bits[30:0], sdata_from_adc};
    end
    if (cur[3]) check("sdo_stream", {30'd0, sdo_oe, sdata_from_adc}, int'(cur[1:0]));
    if (conv_done) begin
      conv_cnt++;
      check("conv_done_width", conv_prev, 0);
    end
    if (frame_error) begin
      ferr_cnt++;
      check("frame_error_width", ferr_prev, 0);
    end
    conv_prev = conv_done;
    ferr_prev = frame_error;
  end

  task automatic run_frame(input int lead, input bit sgl, input bit odd, input bit msbf,
                           input int nclk, input int half, input int cut_at,
                           input bit use_reset, input bit poke);
    int res;
    int conv0;
    int ferr0;
    int last_fall;
    int data_end;
    res       = model_result(sgl, odd, int'(sample_ch0), int'(sample_ch1));
    conv0     = conv_cnt;
    ferr0     = ferr_cnt;
    obs_bits  = '0;
    last_fall = nclk - 1;
    adc_cs    = 1'b0;
    wait_cyc(half);
    for (int f = 0; f < nclk; f++) begin
      if (use_reset && f == cut_at) begin
        #2 rst_n = 1'b0;
        due_cyc.delete();
        due_ent.delete();
        cur = 4'b1000;
        #1;
        check("rst_async_sdo", sdata_from_adc, 0);
        check("rst_async_oe", sdo_oe, 0);
        check("rst_async_conv_done", conv_done, 0);
        check("rst_async_frame_error", frame_error, 0);
        check("rst_async_last_channel", last_channel, 0);
        model_lc = 1'b0;
        wait_cyc(4);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
          adc_sck = 1'b0;
          sdata_to_adc = 1'b1;
          wait_cyc(half);
          adc_sck = 1'b1;
          wait_cyc(half);
        end
        break;
      end
      adc_sck      = 1'b0;
      sdata_to_adc = master_bit(f, lead, sgl, odd, msbf);
      sched(cyc + S + 2, {1'b1, model_fall(f, lead, res, msbf)});
      if (poke && f == lead + 6) begin
        sample_ch0 = ~sample_ch0;
        sample_ch1 = ~sample_ch1;
      end
      wait_cyc(half);
      adc_sck = 1'b1;
      wait_cyc(half);
      if (!use_reset && f == cut_at) begin
        last_fall = f;
        break;
      end
    end
    adc_cs       = 1'b1;
    sdata_to_adc = 1'b0;
    sched(cyc + 1, 4'b0000);
    sched(cyc + S + 2, 4'b1000);
    wait_cyc(2 * half + S + 4);
    data_end = lead + 4 + DB;
    if (use_reset) begin
      check("conv_done_count", conv_cnt - conv0, 0);
      check("frame_error_count", ferr_cnt - ferr0, 0);
    end else begin
      if (last_fall >= lead + 3) model_lc = odd;
      check("conv_done_count", conv_cnt - conv0, (last_fall >= data_end) ? 1 : 0);
      check("frame_error_count", ferr_cnt - ferr0,
            (last_fall >= lead && last_fall < data_end) ? 1 : 0);
    end
    check("last_channel", last_channel, model_lc);
  endtask

  initial begin
    rst_n        = 1'b0;
    adc_cs       = 1'b1;
    adc_sck      = 1'b1;
    sdata_to_adc = 1'b0;
    sample_ch0   = '0;
    sample_ch1   = '0;
    wait_cyc(3);
    check("reset_sdo", sdata_from_adc, 0);
    check("reset_oe", sdo_oe, 0);
    check("reset_conv_done", conv_done, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_last_channel", last_channel, 0);
    check("reset_state", int'(dbg_state), int'(ST_IDLE));
    rst_n = 1'b1;
    wait_cyc(6);

    sample_ch0 = 10'h155;
    sample_ch1 = 10'h2A5;
    run_frame(0, 1'b1, 1'b1, 1'b1, 16, 25, -1, 1'b0, 1'b0);
    check("single_ch1_data", int'(obs_bits[9:0]), 10'b1010100101);

    sample_ch0 = 10'h301;
    sample_ch1 = 10'h0F0;
    run_frame(0, 1'b1, 1'b0, 1'b0, 24, 5, -1, 1'b0, 1'b1);
    check("lsb_tail_data", int'(obs_bits[18:0]), 19'b1100000001_000000011);

    sample_ch0 = 10'd100;
    sample_ch1 = 10'd300;
    run_frame(0, 1'b0, 1'b0, 1'b1, 16, 4, -1, 1'b0, 1'b0);
    check("diff_sat_zero", int'(obs_bits[9:0]), 0);
    run_frame(0, 1'b0, 1'b1, 1'b1, 16, 4, -1, 1'b0, 1'b0);
    check("diff_ch1_minus_ch0", int'(obs_bits[9:0]), 10'h0C8);

    sample_ch0 = 10'h155;
    sample_ch1 = 10'h2A5;
    run_frame(2, 1'b1, 1'b1, 1'b1, 18, 25, -1, 1'b0, 1'b0);
    check("leading_zeros_data", int'(obs_bits[9:0]), 10'b1010100101);

    for (int k = 0; k < 3; k++) begin
      adc_sck      = 1'b0;
      sdata_to_adc = 1'b1;
      wait_cyc(5);
      adc_sck = 1'b1;
      wait_cyc(5);
    end
    sdata_to_adc = 1'b0;
    wait_cyc(8);

    run_frame(0, 1'b1, 1'b1, 1'b1, 16, 25, 10, 1'b0, 1'b0);
    check("abort_partial_data", int'(obs_bits[5:0]), 6'b101010);
    run_frame(0, 1'b1, 1'b1, 1'b1, 16, 25, -1, 1'b0, 1'b0);
    check("after_abort_data", int'(obs_bits[9:0]), 10'b1010100101);

    run_frame(0, 1'b1, 1'b1, 1'b1, 16, 25, 8, 1'b1, 1'b0);
    sample_ch0 = 10'h301;
    sample_ch1 = 10'h0F0;
    run_frame(0, 1'b1, 1'b0, 1'b0, 24, 25, -1, 1'b0, 1'b0);
    check("after_reset_data", int'(obs_bits[18:0]), 19'b1100000001_000000011);

    wait_cyc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, input synchroniser depth for adc_sck/adc_cs/sdata_to_adc.
REQ-002 SHALL have parameter DATA_BITS, default 10, conversion result width.
REQ-003 sysclk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 adc_cs  input  1  chip select from SPI master, active-low.
REQ-006 adc_sck  input  1  serial clock from master, idle high.
REQ-007 sdata_to_adc  input  1  master-to-device config bits.
REQ-008 sdata_from_adc  output  1  device-to-master data bits.
REQ-009 sdo_oe  output  1  high while SDO is validly driven (CS low, past MSBF bit).
REQ-010 sample_ch0, sample_ch1  input  DATA_BITS each  emulated analogue values.
REQ-011 conv_done  output  1  one-sysclk pulse after B0 shifted out.
REQ-012 frame_error  output  1  one-sysclk pulse when CS rises mid-frame.
REQ-013 last_channel  output  1  ODD bit of last accepted config.

Function
REQ-014 SHALL synchronise adc_cs, adc_sck, sdata_to_adc through SYNC_STAGES flops, then detect SCK rising/falling edges by one further register.
REQ-015 SHALL sample sdata_to_adc on detected SCK rising edges; SHALL update sdata_from_adc on detected SCK falling edges.
REQ-016 Supported SCK: high and low phases each >= 4 sysclk cycles; faster SCK is out of scope.
REQ-017 States: IDLE, WAIT_START, GET_SGL, GET_ODD, GET_MSBF, NULL_BIT, DATA, LSB_TAIL, ZERO_FILL.
REQ-018 IDLE -> WAIT_START when synchronised CS falls.
REQ-019 WAIT_START: rising-edge bit 0 ignored (leading zeros); bit 1 -> GET_SGL.
REQ-020 GET_SGL, GET_ODD, GET_MSBF each capture one bit on rising edge, then advance.
REQ-021 Result latched at MSBF rising edge: SGL=1 -> sample of channel ODD; SGL=0,ODD=0 -> ch0-ch1; SGL=0,ODD=1 -> ch1-ch0; differences saturate at 0.
REQ-022 NULL_BIT: next SCK falling edge drives SDO=0, sdo_oe=1.
REQ-023 DATA: next DATA_BITS falling edges drive B9..B0 MSB first; after B0 conv_done pulses.
REQ-024 MSBF=0: following 9 falling edges drive B1..B9 (LSB_TAIL), then ZERO_FILL; MSBF=1: go directly to ZERO_FILL.
REQ-025 ZERO_FILL drives SDO=0 until CS rises.
REQ-026 CS rise from any state -> IDLE next cycle, SDO=0, sdo_oe=0; frame_error pulses if state was GET_SGL..DATA (B0 not yet shifted).
REQ-027 SCK edges while CS high SHALL be ignored.
REQ-028 SDO change SHALL occur SYNC_STAGES+2 sysclk cycles after the raw SCK falling edge.
REQ-029 sample_chX changes after latch SHALL NOT affect the frame in progress.

Reset
REQ-030 rst_n low SHALL force IDLE, sdata_from_adc=0, sdo_oe=0, conv_done=0, frame_error=0, last_channel=0, synchroniser flops to idle values (cs=1, sck=1, sdi=0).
REQ-031 Release mid-frame SHALL wait for CS high then low before accepting a frame.

Structure
REQ-032 Package adc_emu_pkg SHALL hold the state enum and DATA_BITS default constant.
REQ-033 Sub-module spi_edge_sync (synchroniser plus edge detect, per signal) SHALL be instantiated for adc_sck; plain sync for cs/sdi.

Verification
REQ-034 ch1=10'h2A5, config 1,1,1,1 (SGL,ODD=1,MSBF=1) at SCK 1 MHz, 16 clocks -> SDO after null: 1010100101, conv_done once, last_channel=1.
REQ-035 ch0=10'h301, MSBF=0, 24 clocks -> 1100000001 then 000000011, then zeros.
REQ-036 SGL=0,ODD=0, ch0=100, ch1=300 -> data 0; ODD=1 -> data 200 (10'h0C8).
REQ-037 Two leading zeros before start bit -> same data as REQ-034 delayed by two SCK periods.
REQ-038 CS raised after 6th data bit -> frame_error pulse, sdo_oe=0 within SYNC_STAGES+2 cycles; next frame correct.
REQ-039 rst_n asserted mid-DATA -> all outputs 0 asynchronously; post-release frame correct.
